// File: rtl/ocx_tlx_rcv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ocx_tlx_rcv_pkg
// Brief    : Shared types and constants for the TLX receive response buffer.
//            Optional feature macro used by this slice: OCX_TLX_RSP_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
package ocx_tlx_rcv_pkg;

  // Credit return FSM encodings
  typedef enum logic [1:0] {
    CRD_INIT = 2'd0,
    CRD_IDLE = 2'd1,
    CRD_SEND = 2'd2
  } crd_state_e;

  localparam int OCX_TLX_RSP_WIDTH  = 56;
  localparam int OCX_TLX_RSP_DEPTH  = 16;
  localparam int OCX_TLX_RSP_ADDR_W = 4;
  // Credit counts span 0..DEPTH inclusive, hence one extra bit
  localparam int OCX_TLX_CRD_CNT_W  = OCX_TLX_RSP_ADDR_W + 1;

endpackage
`default_nettype wire

// File: rtl/ocx_tlx_rcv_credit_rtn_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ocx_tlx_rcv_credit_rtn_fsm
// Brief    : Accumulates drained entries and returns them to the remote
//            transmitter as link credits, either in batches or on idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ocx_tlx_rcv_credit_rtn_fsm
  import ocx_tlx_rcv_pkg::*;
#(
  parameter int DEPTH        = OCX_TLX_RSP_DEPTH,
  parameter int ADDR_W       = OCX_TLX_RSP_ADDR_W,
  parameter int CREDIT_BATCH = 4,
  parameter int TIMEOUT      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pop,
  input  logic              credit_rtn_taken,
  output logic              credit_rtn_valid,
  output logic [ADDR_W:0]   credit_rtn_count
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  C_DEPTH    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  C_BATCH    = (ADDR_W + 1)'(CREDIT_BATCH);
  localparam logic [TMR_W-1:0] C_TMO_LAST = TMR_W'(TIMEOUT - 1);

  crd_state_e        state_q, state_d;
  logic [ADDR_W:0]   acc_q, acc_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              vld_q, vld_d;
  logic [ADDR_W:0]   acc_inc;

  // Next-state: pops always accumulate; only IDLE may launch a new return.
  // The timer counts cycles with credits pending so a lone pop returns
  // exactly TIMEOUT cycles later.
  always_comb begin
    acc_inc = acc_q + {{ADDR_W{1'b0}}, pop};
    state_d = state_q;
    acc_d   = acc_inc;
    cnt_d   = cnt_q;
    tmr_d   = '0;
    vld_d   = vld_q;
    case (state_q)
      CRD_INIT: begin
        if (credit_rtn_taken) begin
          state_d = CRD_IDLE;
          vld_d   = 1'b0;
        end
      end
      CRD_IDLE: begin
        if ((acc_inc >= C_BATCH) || ((acc_q != '0) && (tmr_q >= C_TMO_LAST))) begin
          state_d = CRD_SEND;
          vld_d   = 1'b1;
          cnt_d   = acc_inc;
          acc_d   = '0;
        end else if (acc_inc != '0) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      CRD_SEND: begin
        if (credit_rtn_taken) begin
          state_d = CRD_IDLE;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = CRD_INIT;
        vld_d   = 1'b1;
        cnt_d   = C_DEPTH;
        acc_d   = '0;
      end
    endcase
  end

  // Credit FSM registers; reset re-advertises the full buffer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CRD_INIT;
      acc_q   <= '0;
      cnt_q   <= C_DEPTH;
      tmr_q   <= '0;
      vld_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      vld_q   <= vld_d;
    end
  end

  assign credit_rtn_valid = vld_q;
  assign credit_rtn_count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ocx_tlx_rcv_rsp_fifo_credit.sv
`default_nettype none
// ============================================================================
// Module   : ocx_tlx_rcv_rsp_fifo_credit
// Brief    : TLX receive response FIFO with valid/ready output and link
//            credit return. Define OCX_TLX_RSP_PARITY_EN to store and check
//            even parity per entry.
// Revision : 1.0 - initial release
// ============================================================================
module ocx_tlx_rcv_rsp_fifo_credit
  import ocx_tlx_rcv_pkg::*;
#(
  parameter int DEPTH        = OCX_TLX_RSP_DEPTH,
  parameter int WIDTH        = OCX_TLX_RSP_WIDTH,
  parameter int ADDR_W       = OCX_TLX_RSP_ADDR_W,
  parameter int CREDIT_BATCH = 4,
  parameter int TIMEOUT      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rsp_in_valid,
  input  logic [WIDTH-1:0]  rsp_in_data,
  output logic              rsp_out_valid,
  output logic [WIDTH-1:0]  rsp_out_data,
  input  logic              rsp_out_ready,
  output logic              credit_rtn_valid,
  output logic [ADDR_W:0]   credit_rtn_count,
  input  logic              credit_rtn_taken,
  output logic [ADDR_W:0]   valid_entry_count,
  output logic              overflow_error,
  output logic              parity_error
);

`ifdef OCX_TLX_RSP_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              full, pop, wr_en;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  head;

  assign full  = (count_q == C_DEPTH);
  assign pop   = (count_q != '0) & rsp_out_ready;
  // A push while full only lands if the head leaves in the same cycle
  assign wr_en = rsp_in_valid & (~full | pop);
  assign head  = mem_q[rd_ptr_q];

`ifdef OCX_TLX_RSP_PARITY_EN
  assign wr_word = {^rsp_in_data, rsp_in_data};
`else
  assign wr_word = rsp_in_data;
`endif

  // Pointer, occupancy and overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, pop};
    ovf_d    = ovf_q | (rsp_in_valid & full & ~pop);
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since occupancy gates visibility
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  // Control state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef OCX_TLX_RSP_PARITY_EN
  logic par_q, par_d;

  // Stored word carries even parity, so any odd XOR on pop is corruption
  always_comb begin
    par_d = par_q | (pop & (^head));
  end

  // Sticky parity error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_error = par_q;
`else
  assign parity_error = 1'b0;
`endif

  assign rsp_out_valid     = (count_q != '0);
  assign rsp_out_data      = head[WIDTH-1:0];
  assign valid_entry_count = count_q;
  assign overflow_error    = ovf_q;

  ocx_tlx_rcv_credit_rtn_fsm #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .CREDIT_BATCH (CREDIT_BATCH),
    .TIMEOUT      (TIMEOUT)
  ) u_crd (
    .clock            (clock),
    .reset            (reset),
    .pop              (pop),
    .credit_rtn_taken (credit_rtn_taken),
    .credit_rtn_valid (credit_rtn_valid),
    .credit_rtn_count (credit_rtn_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_ocx_tlx_rcv_rsp_fifo_credit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ocx_tlx_rcv_rsp_fifo_credit
// Brief    : Scoreboard bench for the TLX receive response FIFO and its
//            credit return logic. Parity checks run when
//            OCX_TLX_RSP_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ocx_tlx_rcv_rsp_fifo_credit;

  localparam int DEPTH = 16;
  localparam int WIDTH = 56;

  logic             clock = 1'b0;
  logic             reset;
  logic             rsp_in_valid;
  logic [WIDTH-1:0] rsp_in_data;
  logic             rsp_out_valid;
  logic [WIDTH-1:0] rsp_out_data;
  logic             rsp_out_ready;
  logic             credit_rtn_valid;
  logic [4:0]       credit_rtn_count;
  logic             credit_rtn_taken;
  logic [4:0]       valid_entry_count;
  logic             overflow_error;
  logic             parity_error;

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] sb [$];
  logic exp_ovf = 1'b0;

  ocx_tlx_rcv_rsp_fifo_credit dut (
    .clock             (clock),
    .reset             (reset),
    .rsp_in_valid      (rsp_in_valid),
    .rsp_in_data       (rsp_in_data),
    .rsp_out_valid     (rsp_out_valid),
    .rsp_out_data      (rsp_out_data),
    .rsp_out_ready     (rsp_out_ready),
    .credit_rtn_valid  (credit_rtn_valid),
    .credit_rtn_count  (credit_rtn_count),
    .credit_rtn_taken  (credit_rtn_taken),
    .valid_entry_count (valid_entry_count),
    .overflow_error    (overflow_error),
    .parity_error      (parity_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[WIDTH-1:0];
  endfunction

  // One cycle: check current outputs against the model, drive, advance
  task automatic step(input logic iv, input logic [WIDTH-1:0] d,
                      input logic rdy, input logic tk);
    logic do_pop, accept;
    logic [WIDTH-1:0] e;
    chk("out_valid", rsp_out_valid, (sb.size() != 0));
    chk("entry_cnt", valid_entry_count, sb.size());
    chk("overflow", overflow_error, exp_ovf);
    rsp_in_valid     = iv;
    rsp_in_data      = d;
    rsp_out_ready    = rdy;
    credit_rtn_taken = tk;
    do_pop = rdy && (sb.size() != 0);
    accept = iv && ((sb.size() < DEPTH) || do_pop);
    if (iv && !accept) exp_ovf = 1'b1;
    if (do_pop) begin
      e = sb.pop_front();
      chk("rsp_data", rsp_out_data, e);
    end
    if (accept) sb.push_back(d);
    @(posedge clock);
    #1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    reset            = 1'b1;
    rsp_in_valid     = 1'b0;
    rsp_in_data      = '0;
    rsp_out_ready    = 1'b0;
    credit_rtn_taken = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state and INIT advertisement
    chk("rst_crd_valid", credit_rtn_valid, 1);
    chk("rst_crd_count", credit_rtn_count, 16);
    chk("rst_parity", parity_error, 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    chk("init_hold_valid", credit_rtn_valid, 1);
    chk("init_hold_count", credit_rtn_count, 16);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("init_taken_valid", credit_rtn_valid, 0);

    // Fill, overflow, full push+pop, drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd_data(), 1'b0, 1'b1);
    chk("full_cnt", valid_entry_count, 16);
    step(1'b1, rnd_data(), 1'b0, 1'b1);
    chk("ovf_set", overflow_error, 1);
    chk("ovf_cnt", valid_entry_count, 16);
    step(1'b1, rnd_data(), 1'b1, 1'b1);
    chk("full_pushpop_cnt", valid_entry_count, 16);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b1);
    chk("drained_cnt", valid_entry_count, 0);
    chk("ovf_sticky", overflow_error, 1);
    flush(40);

    // Steady push+pop with 5 resident, wrapping the pointers
    for (int i = 0; i < 5; i++) step(1'b1, rnd_data(), 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, rnd_data(), 1'b1, 1'b1);
      chk("wrap_cnt", valid_entry_count, 5);
    end
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b1);
    flush(40);

    // Batch return after 4 pops; a 5th pop during SEND rolls into the next
    for (int i = 0; i < 5; i++) step(1'b1, rnd_data(), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("batch_pre_valid", credit_rtn_valid, 0);
      step(1'b0, '0, 1'b1, 1'b1);
    end
    chk("batch_valid", credit_rtn_valid, 1);
    chk("batch_count", credit_rtn_count, 4);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("batch_taken", credit_rtn_valid, 0);
    n = 0;
    while (!credit_rtn_valid && n < 60) begin
      step(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    chk("batch_next_seen", credit_rtn_valid, 1);
    chk("batch_next_count", credit_rtn_count, 1);
    flush(40);

    // Single pop returns exactly TIMEOUT cycles later
    step(1'b1, rnd_data(), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    n = 1;
    while (!credit_rtn_valid && n < 60) begin
      step(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    chk("tmo_latency", n, 32);
    chk("tmo_count", credit_rtn_count, 1);
    flush(40);

`ifdef OCX_TLX_RSP_PARITY_EN
    // Corrupt the stored parity bit of the head entry, then pop it
    step(1'b1, rnd_data(), 1'b0, 1'b1);
    dut.mem_q[dut.rd_ptr_q][WIDTH] = ~dut.mem_q[dut.rd_ptr_q][WIDTH];
    chk("par_pre", parity_error, 0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("par_set", parity_error, 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("par_sticky", parity_error, 1);
`else
    chk("par_tied", parity_error, 0);
`endif

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, rnd_data(), 1'b0, 1'b1);
    rsp_in_valid = 1'b0;
    credit_rtn_taken = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_cnt", valid_entry_count, 0);
    chk("arst_valid", rsp_out_valid, 0);
    chk("arst_ovf", overflow_error, 0);
    chk("arst_crd_valid", credit_rtn_valid, 1);
    chk("arst_crd_count", credit_rtn_count, 16);
    sb.delete();
    exp_ovf = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1'b1, rnd_data(), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("post_rst_cnt", valid_entry_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
